idct4_row_pipe: RTL and testbench

Parametrised successor to the single-output IDCT MAC column. It computes all four outputs of the HEVC 4-point inverse DCT per accepted beat, using even/odd butterfly decomposition with coefficients 64, 83 and 36. Each beat selects a rounding shift (first or second transform pass) at run time, and results are saturated to the output width. It sits between the coefficient dequantiser / transpose buffer and the residual adder, with valid/ready flow control on both sides.

---
 rtl/idct_pkg.sv | 43 ++++
 rtl/idct_round_sat.sv | 43 ++++
 rtl/idct4_row_pipe.sv | 140 ++++++++++++++
 tb/tb_idct4_row_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared constants and helpers for the 4-point HEVC inverse DCT row.
//   C64/C83/C36 : transform coefficients (realised as shift-add in the datapath)
//   acc_w()     : accumulator width for a given input width
//   sat_clip()  : signed clip of a wide value to an out_w-bit range + clip flag
package idct_pkg;

    localparam int C64 = 64;   // 1 << 6
    localparam int C83 = 83;   // 64 + 16 + 2 + 1
    localparam int C36 = 36;   // 32 + 4

    // Wide enough to carry any rounded accumulator value into the clipper.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    clip;
    } sat_t;

    // 64*(s0+s2) + 83*s1 + 36*s3 grows by at most 8 bits over the inputs.
    function automatic int acc_w(input int in_w);
        return in_w + 8;
    endfunction

    function automatic sat_t sat_clip(input logic signed [SAT_W-1:0] v,
                                      input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.val  = v;
        r.clip = 1'b0;
        if (v > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (v < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/idct_round_sat.sv
// idct_round_sat: combinational round / arithmetic shift / clip of one lane.
//   y_in  : ACC_W-bit signed butterfly result
//   sel   : 0 -> shift by SHIFT_A, 1 -> shift by SHIFT_B
//   y_out : OUT_W-bit signed clipped result
//   clip  : high when y_out was clipped
module idct_round_sat
    import idct_pkg::*;
#(
    parameter int ACC_W   = 33,
    parameter int OUT_W   = 16,
    parameter int SHIFT_A = 7,
    parameter int SHIFT_B = 12
) (
    input  logic [ACC_W-1:0] y_in,
    input  logic             sel,
    output logic [OUT_W-1:0] y_out,
    output logic             clip
);

    // One guard bit so the rounding add can never wrap.
    logic signed [ACC_W:0]   ye;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   r;
    logic signed [SAT_W-1:0] r_ext;
    logic [SAT_W-1:OUT_W]    unused_hi;
    sat_t                    s;
    int                      sh;

    always_comb begin
        sh  = sel ? SHIFT_B : SHIFT_A;
        ye  = {y_in[ACC_W-1], y_in};
        rnd = '0;
        // Zero shift means pass-through: no half-LSB rounding term.
        if (sh != 0) rnd = (ACC_W+1)'(1) << (sh - 1);
        r     = (ye + rnd) >>> sh;
        r_ext = {{(SAT_W-ACC_W-1){r[ACC_W]}}, r};
        s     = sat_clip(r_ext, OUT_W);
        y_out = s.val[OUT_W-1:0];
        clip  = s.clip;
        unused_hi = s.val[SAT_W-1:OUT_W];
    end

endmodule

// File: rtl/idct4_row_pipe.sv
// idct4_row_pipe: 3-stage pipelined HEVC 4-point inverse DCT (all four outputs
// per beat) with run-time selectable rounding shift and output saturation.
//   clk, reset          : clock, async active-high reset
//   in_valid / in_ready : input handshake; shift_sel and d_in_* ride with the beat
//   d_in_1..d_in_4      : signed coefficients s0..s3 (IN_W)
//   out_valid/out_ready : output handshake
//   y_out_1..y_out_4    : signed results y0..y3 (OUT_W)
//   sat_flag            : any lane of this beat was clipped
module idct4_row_pipe
    import idct_pkg::*;
#(
    parameter int IN_W    = 25,
    parameter int OUT_W   = 16,
    parameter int SHIFT_A = 7,
    parameter int SHIFT_B = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_sel,
    input  logic [IN_W-1:0]  d_in_1,
    input  logic [IN_W-1:0]  d_in_2,
    input  logic [IN_W-1:0]  d_in_3,
    input  logic [IN_W-1:0]  d_in_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y_out_1,
    output logic [OUT_W-1:0] y_out_2,
    output logic [OUT_W-1:0] y_out_3,
    output logic [OUT_W-1:0] y_out_4,
    output logic             sat_flag
);

    localparam int ACC_W  = acc_w(IN_W);
    localparam int NL     = 4;
    localparam int STAGES = 3;
    localparam int E_SH   = $clog2(C64);

    // 83x = 64x + 16x + 2x + x
    function automatic logic signed [ACC_W-1:0] mul83(input logic signed [ACC_W-1:0] x);
        return (x <<< 6) + (x <<< 4) + (x <<< 1) + x;
    endfunction

    // 36x = 32x + 4x
    function automatic logic signed [ACC_W-1:0] mul36(input logic signed [ACC_W-1:0] x);
        return (x <<< 5) + (x <<< 2);
    endfunction

    logic en;
    logic [STAGES:1] vld_pipe;

    logic signed [ACC_W-1:0] s0, s1, s2, s3;
    logic signed [ACC_W-1:0] e0_c, e1_c, o0_c, o1_c;
    logic signed [ACC_W-1:0] e0_r, e1_r, o0_r, o1_r;
    logic                    sel1, sel2;

    logic [NL-1:0][ACC_W-1:0] y_c;
    logic [NL-1:0][ACC_W-1:0] y_r;
    logic [NL-1:0][OUT_W-1:0] rs_y;
    logic [NL-1:0]            rs_clip;
    logic [NL-1:0][OUT_W-1:0] y_q;
    logic                     sat_q;

    // Whole pipe moves in lock-step; it only freezes when the output is held.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    assign s0 = {{(ACC_W-IN_W){d_in_1[IN_W-1]}}, d_in_1};
    assign s1 = {{(ACC_W-IN_W){d_in_2[IN_W-1]}}, d_in_2};
    assign s2 = {{(ACC_W-IN_W){d_in_3[IN_W-1]}}, d_in_3};
    assign s3 = {{(ACC_W-IN_W){d_in_4[IN_W-1]}}, d_in_4};

    // Even/odd butterfly terms.
    assign e0_c = (s0 + s2) <<< E_SH;
    assign e1_c = (s0 - s2) <<< E_SH;
    assign o0_c = mul83(s1) + mul36(s3);
    assign o1_c = mul36(s1) - mul83(s3);

    assign y_c[0] = e0_r + o0_r;
    assign y_c[1] = e1_r + o1_r;
    assign y_c[2] = e1_r - o1_r;
    assign y_c[3] = e0_r - o0_r;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        idct_round_sat #(
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W),
            .SHIFT_A(SHIFT_A),
            .SHIFT_B(SHIFT_B)
        ) u_rs (
            .y_in (y_r[i]),
            .sel  (sel2),
            .y_out(rs_y[i]),
            .clip (rs_clip[i])
        );
    end

    // Data registers load only behind a valid beat so the output holds the
    // last real result through bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            e0_r     <= '0;
            e1_r     <= '0;
            o0_r     <= '0;
            o1_r     <= '0;
            sel1     <= 1'b0;
            y_r      <= '0;
            sel2     <= 1'b0;
            y_q      <= '0;
            sat_q    <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) begin
                e0_r <= e0_c;
                e1_r <= e1_c;
                o0_r <= o0_c;
                o1_r <= o1_c;
                sel1 <= shift_sel;
            end
            if (vld_pipe[1]) begin
                y_r  <= y_c;
                sel2 <= sel1;
            end
            if (vld_pipe[2]) begin
                y_q   <= rs_y;
                sat_q <= |rs_clip;
            end
        end
    end

    assign y_out_1  = y_q[0];
    assign y_out_2  = y_q[1];
    assign y_out_3  = y_q[2];
    assign y_out_4  = y_q[3];
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_idct4_row_pipe.sv
// Directed bench for idct4_row_pipe: table of hand-computed vectors applied as
// isolated beats, then a back-pressured stream and a mid-stall reset.
module tb_idct4_row_pipe;

    localparam int IN_W  = 25;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             shift_sel = 1'b0;
    logic             out_ready = 1'b1;
    logic [IN_W-1:0]  d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic             in_ready, out_valid, sat_flag;
    logic [OUT_W-1:0] y1, y2, y3, y4;

    idct4_row_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .shift_sel(shift_sel),
        .d_in_1   (d1),
        .d_in_2   (d2),
        .d_in_3   (d3),
        .d_in_4   (d4),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out_1  (y1),
        .y_out_2  (y2),
        .y_out_3  (y3),
        .y_out_4  (y4),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   s0, s1, s2, s3;
        logic sel;
        int   y0, y1, y2, y3;
        logic sat;
    } vec_t;

    vec_t tbl [8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_vec(input int i);
        in_valid  = 1'b1;
        shift_sel = tbl[i].sel;
        d1 = IN_W'(tbl[i].s0);
        d2 = IN_W'(tbl[i].s1);
        d3 = IN_W'(tbl[i].s2);
        d4 = IN_W'(tbl[i].s3);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        shift_sel = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    endtask

    task automatic chk_out(input string tag, input int i);
        chk({tag, ".y0"}, $signed(y1), tbl[i].y0);
        chk({tag, ".y1"}, $signed(y2), tbl[i].y1);
        chk({tag, ".y2"}, $signed(y3), tbl[i].y2);
        chk({tag, ".y3"}, $signed(y4), tbl[i].y3);
        chk({tag, ".sat"}, sat_flag, tbl[i].sat);
    endtask

    // One isolated beat: out_valid must appear exactly 3 edges after acceptance.
    task automatic single_beat(input string tag, input int i);
        @(negedge clk); drive_vec(i);
        @(negedge clk); idle();
        chk({tag, ".lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".lat2"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".valid"}, out_valid, 1);
        chk_out(tag, i);
    endtask

    int   order [6];
    int   k, got;
    logic stalled_prev;
    logic [OUT_W-1:0] hold [4];
    logic hold_sat;

    initial begin
        //            s0        s1   s2   s3   sel   y0      y1      y2      y3      sat
        tbl[0] = '{64,       0,   0,   0,   1'b0, 32,     32,     32,     32,     1'b0};
        tbl[1] = '{0,        1,   0,   0,   1'b0, 1,      0,      0,      -1,     1'b0};
        tbl[2] = '{100,      200, 300, 400, 1'b1, 14,     -9,     3,      -1,     1'b0};
        tbl[3] = '{1048576,  0,   0,   0,   1'b0, 32767,  32767,  32767,  32767,  1'b1};
        tbl[4] = '{-1048576, 0,   0,   0,   1'b0, -32768, -32768, -32768, -32768, 1'b1};
        tbl[5] = '{0,        0,   0,   1,   1'b0, 0,      -1,     1,      0,      1'b0};
        tbl[6] = '{1000,     0,   0,   0,   1'b1, 16,     16,     16,     16,     1'b0};
        tbl[7] = '{1000,     0,   0,   0,   1'b0, 500,    500,    500,    500,    1'b0};

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.y0", y1, 0);
        chk("rst.y3", y4, 0);
        chk("rst.sat", sat_flag, 0);
        reset = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);

        // Table-driven isolated beats
        for (int i = 0; i < 8; i++) single_beat($sformatf("vec%0d", i), i);

        // Back-pressured stream with alternating shift_sel
        order = '{7, 6, 0, 2, 1, 6};
        k = 0;
        got = 0;
        stalled_prev = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 8);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp.in_ready_low", in_ready, 0);
                if (stalled_prev) begin
                    chk("bp.hold.y0", y1, hold[0]);
                    chk("bp.hold.y1", y2, hold[1]);
                    chk("bp.hold.y2", y3, hold[2]);
                    chk("bp.hold.y3", y4, hold[3]);
                    chk("bp.hold.sat", sat_flag, hold_sat);
                end
                stalled_prev = 1'b1;
                hold[0] = y1; hold[1] = y2; hold[2] = y3; hold[3] = y4;
                hold_sat = sat_flag;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk_out($sformatf("bp.beat%0d", got), order[got]);
                got++;
            end
            if (k < 6) begin
                drive_vec(order[k]);
                if (in_ready) k++;
            end else begin
                idle();
            end
        end
        chk("bp.count", got, 6);
        idle();
        out_ready = 1'b1;

        // Reset with three beats in flight during a stall
        @(negedge clk); out_ready = 1'b0; drive_vec(3);
        @(negedge clk); drive_vec(7);
        @(negedge clk); drive_vec(6);
        @(negedge clk); idle();
        chk("rs.pre_valid", out_valid, 1);
        chk("rs.pre_y0", $signed(y1), 32767);
        chk("rs.pre_sat", sat_flag, 1);
        chk("rs.pre_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("rs.async_valid", out_valid, 0);
        chk("rs.async_y0", y1, 0);
        chk("rs.async_y1", y2, 0);
        chk("rs.async_y2", y3, 0);
        chk("rs.async_y3", y4, 0);
        chk("rs.async_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs.in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rs.stale%0d", i), out_valid, 0);
        end
        single_beat("rs.after", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
